// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: PS/2 keyboard receiver that filters the clock, frames bytes and
// folds E0/F0 prefixes into buffered key events with ready/valid handoff.
module ps2_key_sequencer #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       frame_err,
  output logic       overflow
);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] c_sync, d_sync, state;
  logic filt, filt_d, par_ok, ext_pend, brk_pend;
  logic [FW-1:0] f_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic din, strobe, tmo, start_err, stop_end, byte_ok, err, evt;
  assign din       = d_sync[1];
  assign strobe    = filt_d & ~filt;
  assign tmo       = state != IDLE && !strobe && to_cnt == TW'(TIMEOUT_CYC - 1);
  assign start_err = strobe && state == IDLE && din;
  assign stop_end  = strobe && state == STOP;
  assign byte_ok   = stop_end && par_ok && din;
  assign err       = start_err || tmo || (stop_end && !byte_ok);
  assign evt       = byte_ok && shreg != 8'hE0 && shreg != 8'hF0;
  // The filtered level flips only once the new level has been seen FILTER_LEN times in a row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      f_cnt  <= '0;
    end else begin
      c_sync <= {c_sync[0], PS2Clk};
      d_sync <= {d_sync[0], PS2Data};
      filt_d <= filt;
      f_cnt  <= (c_sync[1] == filt || f_cnt == FW'(FILTER_LEN - 1)) ? '0 : f_cnt + 1'b1;
      if (c_sync[1] != filt && f_cnt == FW'(FILTER_LEN - 1)) filt <= c_sync[1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      to_cnt <= (state == IDLE || strobe || tmo) ? '0 : to_cnt + 1'b1;
      if (tmo) state <= IDLE;
      else if (strobe)
        case (state)
          IDLE: begin
            state   <= din ? IDLE : DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= bit_cnt == 3'd7 ? PARITY : DATA;
          end
          PARITY: begin
            par_ok <= ^{shreg, din};
            state  <= STOP;
          end
          default: state <= IDLE;
        endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_brk   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err;
      overflow  <= evt && key_valid && !key_ready;
      if (err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        ext_pend <= shreg == 8'hE0 ? 1'b1 : shreg == 8'hF0 ? ext_pend : 1'b0;
        brk_pend <= shreg == 8'hF0 ? 1'b1 : shreg == 8'hE0 ? brk_pend : 1'b0;
      end
      if (evt && (!key_valid || key_ready)) begin
        key_valid <= 1'b1;
        key_code  <= shreg;
        key_ext   <= ext_pend;
        key_brk   <= brk_pend;
      end else if (key_ready) key_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: directed frames against the PS/2 key sequencer with hand-computed expectations.
module tb_ps2_key_sequencer;
  localparam int TMO = 200;
  logic clk = 0, rst_n = 0, PS2Clk = 1, PS2Data = 1, key_ready = 1;
  logic key_valid, key_ext, key_brk, frame_err, overflow;
  logic [7:0] key_code;
  int n_vec = 0, n_err = 0;
  int ev_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] last_code;
  logic last_ext, last_brk;
  ps2_key_sequencer #(.FILTER_LEN(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_ext(key_ext), .key_brk(key_brk), .frame_err(frame_err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (key_valid && key_ready) begin
      ev_cnt++;
      last_code = key_code;
      last_ext  = key_ext;
      last_brk  = key_brk;
    end
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    PS2Data = b;
    cyc(5);
    PS2Clk = 0;
    cyc(10);
    PS2Clk = 1;
    cyc(5);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(1'b1);
    PS2Data = 1;
    cyc(20);
  endtask
  task automatic test_reset;
    cyc(3);
    if (key_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", key_valid); n_err++; end
    n_vec++;
    if (key_code !== 8'h00) begin $display("FAIL reset_code got %h want 00", key_code); n_err++; end
    n_vec++;
    if ({key_ext, key_brk} !== 2'b00) begin $display("FAIL reset_ext_brk got %b want 00", {key_ext, key_brk}); n_err++; end
    n_vec++;
    if ({frame_err, overflow} !== 2'b00) begin $display("FAIL reset_err_ov got %b want 00", {frame_err, overflow}); n_err++; end
    n_vec++;
    rst_n = 1;
    cyc(5);
  endtask
  task automatic test_make;
    int e0 = ev_cnt, f0 = fe_cnt;
    send_frame(8'h1C, 0);
    if (ev_cnt - e0 !== 1) begin $display("FAIL make_count got %0d want 1", ev_cnt - e0); n_err++; end
    n_vec++;
    if ({last_ext, last_brk, last_code} !== {2'b00, 8'h1C}) begin $display("FAIL make_event got %b%b_%h want 00_1c", last_ext, last_brk, last_code); n_err++; end
    n_vec++;
    if (fe_cnt - f0 !== 0) begin $display("FAIL make_err got %0d want 0", fe_cnt - f0); n_err++; end
    n_vec++;
    if (key_valid !== 1'b0) begin $display("FAIL make_valid_cleared got %b want 0", key_valid); n_err++; end
    n_vec++;
  endtask
  task automatic test_release;
    int e0 = ev_cnt;
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    if (ev_cnt - e0 !== 1) begin $display("FAIL release_count got %0d want 1", ev_cnt - e0); n_err++; end
    n_vec++;
    if ({last_ext, last_brk, last_code} !== {2'b01, 8'h1C}) begin $display("FAIL release_event got %b%b_%h want 01_1c", last_ext, last_brk, last_code); n_err++; end
    n_vec++;
  endtask
  task automatic test_ext_release;
    int e0 = ev_cnt;
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h74, 0);
    if (ev_cnt - e0 !== 1) begin $display("FAIL ext_release_count got %0d want 1", ev_cnt - e0); n_err++; end
    n_vec++;
    if ({last_ext, last_brk, last_code} !== {2'b11, 8'h74}) begin $display("FAIL ext_release_event got %b%b_%h want 11_74", last_ext, last_brk, last_code); n_err++; end
    n_vec++;
  endtask
  task automatic test_bad_parity;
    int e0 = ev_cnt, f0 = fe_cnt;
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 1);
    if (fe_cnt - f0 !== 1) begin $display("FAIL parity_err got %0d want 1", fe_cnt - f0); n_err++; end
    n_vec++;
    if (ev_cnt - e0 !== 0) begin $display("FAIL parity_noevent got %0d want 0", ev_cnt - e0); n_err++; end
    n_vec++;
    send_frame(8'h1C, 0);
    if ({ev_cnt - e0, last_ext, last_brk, last_code} !== {32'd1, 2'b00, 8'h1C}) begin $display("FAIL parity_recover got %0d %b%b_%h want 1 00_1c", ev_cnt - e0, last_ext, last_brk, last_code); n_err++; end
    n_vec++;
  endtask
  task automatic test_start_err;
    int f0 = fe_cnt, e0 = ev_cnt;
    send_bit(1'b1);
    cyc(20);
    if (fe_cnt - f0 !== 1) begin $display("FAIL start_err got %0d want 1", fe_cnt - f0); n_err++; end
    n_vec++;
    send_frame(8'hE1, 0);
    if ({ev_cnt - e0, last_ext, last_brk, last_code} !== {32'd1, 2'b00, 8'hE1}) begin $display("FAIL e1_plain got %0d %b%b_%h want 1 00_e1", ev_cnt - e0, last_ext, last_brk, last_code); n_err++; end
    n_vec++;
  endtask
  task automatic test_timeout;
    int f0 = fe_cnt, e0 = ev_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(TMO + 10);
    if (fe_cnt - f0 !== 1) begin $display("FAIL timeout_err got %0d want 1", fe_cnt - f0); n_err++; end
    n_vec++;
    send_frame(8'h29, 0);
    if ({ev_cnt - e0, last_code} !== {32'd1, 8'h29}) begin $display("FAIL timeout_recover got %0d %h want 1 29", ev_cnt - e0, last_code); n_err++; end
    n_vec++;
  endtask
  task automatic test_backpressure;
    int o0 = ov_cnt;
    key_ready = 0;
    send_frame(8'h1C, 0);
    send_frame(8'h32, 0);
    if ({key_valid, key_code} !== {1'b1, 8'h1C}) begin $display("FAIL bp_hold got %b_%h want 1_1c", key_valid, key_code); n_err++; end
    n_vec++;
    if (ov_cnt - o0 !== 1) begin $display("FAIL bp_overflow got %0d want 1", ov_cnt - o0); n_err++; end
    n_vec++;
    key_ready = 1;
    cyc(1);
    if (key_valid !== 1'b0) begin $display("FAIL bp_release got %b want 0", key_valid); n_err++; end
    n_vec++;
  endtask
  task automatic test_reset_midframe;
    int e0;
    key_ready = 0;
    send_frame(8'h4A, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2 rst_n = 0;
    #1;
    if ({key_valid, key_code} !== 9'h000) begin $display("FAIL async_reset got %b_%h want 0_00", key_valid, key_code); n_err++; end
    n_vec++;
    cyc(3);
    rst_n = 1;
    key_ready = 1;
    cyc(5);
    e0 = ev_cnt;
    send_frame(8'h1C, 0);
    if ({ev_cnt - e0, last_ext, last_brk, last_code} !== {32'd1, 2'b00, 8'h1C}) begin $display("FAIL reset_recover got %0d %b%b_%h want 1 00_1c", ev_cnt - e0, last_ext, last_brk, last_code); n_err++; end
    n_vec++;
  endtask
  initial begin
    test_reset;
    test_make;
    test_release;
    test_ext_release;
    test_bad_parity;
    test_start_err;
    test_timeout;
    test_backpressure;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
